active_list_rob: RTL and testbench

Parametrised in-order retirement buffer (active list) for the out-of-order MIPS core. It sits between rename, write-back and the commit consumers: the register file, the free list and the store path to memory. It allocates one entry per renamed instruction, collects write-back results by tag, and retires up to COMMIT_WIDTH completed entries per cycle in program order. On a partial or full flush it walks back from the tail one entry per cycle, returning previous mappings to the register map table.

---
 rtl/active_list_rob.sv | 180 ++++++++++++++++++
 tb/tb_active_list_rob.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/active_list_rob.sv
// In-order retirement buffer (active list) for the out-of-order core.
// Allocates one entry per renamed instruction and records write-back
// results by tag. It retires up to COMMIT_WIDTH done entries per cycle in
// program order. On a flush it walks back from the tail one entry per cycle
// and returns the previous mappings to the map table.
module active_list_rob #(
  parameter int DEPTH        = 32,
  parameter int COMMIT_WIDTH = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int PREG_W       = 6,
  parameter int LREG_W       = 5,
  localparam int TAG_W       = $clog2(DEPTH)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     alloc_valid,
  output logic                                     alloc_ready,
  input  logic [LREG_W-1:0]                        alloc_logical,
  input  logic [PREG_W-1:0]                        alloc_new_phys,
  input  logic [PREG_W-1:0]                        alloc_prev_phys,
  input  logic                                     alloc_reg_we,
  input  logic                                     alloc_is_store,
  output logic [TAG_W-1:0]                         alloc_tag,
  input  logic                                     wb_valid,
  input  logic [TAG_W-1:0]                         wb_tag,
  input  logic [DATA_WIDTH-1:0]                    wb_data,
  input  logic [DATA_WIDTH-1:0]                    wb_mem_addr,
  input  logic                                     mem_ready,
  output logic [COMMIT_WIDTH-1:0]                  commit_valid,
  output logic [COMMIT_WIDTH-1:0]                  commit_reg_we,
  output logic [COMMIT_WIDTH-1:0]                  commit_mem_we,
  output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]      commit_phys,
  output logic [COMMIT_WIDTH-1:0][LREG_W-1:0]      commit_logical,
  output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]      commit_free_phys,
  output logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]  commit_data,
  output logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]  commit_mem_addr,
  input  logic                                     flush_valid,
  input  logic                                     flush_all,
  input  logic [TAG_W-1:0]                         flush_tag,
  output logic                                     rb_valid,
  output logic [LREG_W-1:0]                        rb_logical,
  output logic [PREG_W-1:0]                        rb_prev_phys,
  output logic                                     busy,
  output logic [TAG_W:0]                           count
);

  typedef enum logic {IDLE = 1'b0, ROLLBACK = 1'b1} state_t;

  typedef struct packed {
    logic [LREG_W-1:0]     logical;
    logic [PREG_W-1:0]     new_phys;
    logic [PREG_W-1:0]     prev_phys;
    logic                  reg_we;
    logic                  is_store;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] addr;
  } entry_t;

  entry_t                  ent [DEPTH];
  logic [DEPTH-1:0]        done;
  logic [TAG_W-1:0]        head, tail, stop;
  state_t                  state, state_n;

  logic                    idle, do_alloc, wb_hit, need_rb, rb_last, run;
  logic [TAG_W-1:0]        stop_n, tail_m1, wb_off;
  logic [COMMIT_WIDTH-1:0] elig, take;
  logic [TAG_W:0]          n_ret;

  assign idle        = (state == IDLE);
  assign busy        = ~idle;
  assign alloc_ready = idle && (count < (TAG_W+1)'(DEPTH));
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid & alloc_ready & ~flush_valid;
  assign tail_m1     = tail - TAG_W'(1);
  assign rb_last     = (tail_m1 == stop);

  // A write-back only lands on an occupied slot, and never while unwinding.
  assign wb_off = wb_tag - head;
  assign wb_hit = wb_valid & idle & ({1'b0, wb_off} < count);

  // flush_all decides on count rather than tail==head, so a full buffer
  // still rolls back all of its entries.
  assign stop_n  = flush_all ? head : flush_tag + TAG_W'(1);
  assign need_rb = flush_all ? (count != '0) : (tail != stop_n);

  assign rb_valid     = busy;
  assign rb_logical   = busy ? ent[tail_m1].logical   : '0;
  assign rb_prev_phys = busy ? ent[tail_m1].prev_phys : '0;

  // Per-slot eligibility and gated commit outputs.
  for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_slot
    logic [TAG_W-1:0] idx;
    logic             st_ok;
    assign idx = head + TAG_W'(g);
    if (g == 0) begin : g_s0
      assign st_ok = mem_ready;
    end else begin : g_sn
      assign st_ok = 1'b0;
    end
    assign elig[g] = ((TAG_W+1)'(g) < count) && done[idx] && (!ent[idx].is_store || st_ok);
    assign commit_valid[g]     = take[g];
    assign commit_reg_we[g]    = take[g] & ent[idx].reg_we;
    assign commit_mem_we[g]    = take[g] & ent[idx].is_store;
    assign commit_phys[g]      = take[g] ? ent[idx].new_phys  : '0;
    assign commit_logical[g]   = take[g] ? ent[idx].logical   : '0;
    assign commit_free_phys[g] = take[g] ? ent[idx].prev_phys : '0;
    assign commit_data[g]      = take[g] ? ent[idx].data      : '0;
    assign commit_mem_addr[g]  = take[g] ? ent[idx].addr      : '0;
  end

  // Retirement stops at the first slot that cannot go.
  always_comb begin
    run  = idle & ~flush_valid;
    take = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      run     = run & elig[i];
      take[i] = run;
    end
  end

  assign n_ret = (TAG_W+1)'($countones(take));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state: enter rollback on a flush with work, leave on reaching stop.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (flush_valid && need_rb) state_n = ROLLBACK;
      ROLLBACK: if (rb_last) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Pointers, occupancy and done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      stop  <= '0;
      count <= '0;
      done  <= '0;
    end else if (idle) begin
      if (flush_valid) begin
        stop <= stop_n;
      end else begin
        if (do_alloc) begin
          tail       <= tail + TAG_W'(1);
          done[tail] <= 1'b0;
        end
        head  <= head + n_ret[TAG_W-1:0];
        count <= count + {{TAG_W{1'b0}}, do_alloc} - n_ret;
      end
      if (wb_hit) done[wb_tag] <= 1'b1;
    end else begin
      tail  <= tail_m1;
      count <= count - (TAG_W+1)'(1);
    end
  end

  // Entry payload storage; contents are only observed through occupied slots.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      ent[tail].logical   <= alloc_logical;
      ent[tail].new_phys  <= alloc_new_phys;
      ent[tail].prev_phys <= alloc_prev_phys;
      ent[tail].reg_we    <= alloc_reg_we;
      ent[tail].is_store  <= alloc_is_store;
    end
    if (wb_hit) begin
      ent[wb_tag].data <= wb_data;
      ent[wb_tag].addr <= wb_mem_addr;
    end
  end

endmodule

// File: tb/tb_active_list_rob.sv
// Scoreboard bench for active_list_rob: allocations push tags into an
// in-order queue and commits pop and compare against recorded fields.
// Flushes move squashed tags into a rollback queue that rb_valid drains.
module tb_active_list_rob;
  localparam int DEPTH = 32, CW = 2, DW = 32, PW = 6, LW = 5, TW = 5;

  logic clk = 1'b0, rst_n = 1'b1;
  logic alloc_valid = 0, alloc_ready, alloc_reg_we = 0, alloc_is_store = 0;
  logic [LW-1:0] alloc_logical = '0;
  logic [PW-1:0] alloc_new_phys = '0, alloc_prev_phys = '0;
  logic [TW-1:0] alloc_tag, wb_tag = '0, flush_tag = '0;
  logic wb_valid = 0, mem_ready = 1, flush_valid = 0, flush_all = 0;
  logic [DW-1:0] wb_data = '0, wb_mem_addr = '0;
  logic [CW-1:0] commit_valid, commit_reg_we, commit_mem_we;
  logic [CW-1:0][PW-1:0] commit_phys, commit_free_phys;
  logic [CW-1:0][LW-1:0] commit_logical;
  logic [CW-1:0][DW-1:0] commit_data, commit_mem_addr;
  logic rb_valid, busy;
  logic [LW-1:0] rb_logical;
  logic [PW-1:0] rb_prev_phys;
  logic [TW:0] count;

  active_list_rob dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_logical(alloc_logical), .alloc_new_phys(alloc_new_phys),
    .alloc_prev_phys(alloc_prev_phys), .alloc_reg_we(alloc_reg_we),
    .alloc_is_store(alloc_is_store), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_mem_addr(wb_mem_addr),
    .mem_ready(mem_ready),
    .commit_valid(commit_valid), .commit_reg_we(commit_reg_we), .commit_mem_we(commit_mem_we),
    .commit_phys(commit_phys), .commit_logical(commit_logical),
    .commit_free_phys(commit_free_phys), .commit_data(commit_data),
    .commit_mem_addr(commit_mem_addr),
    .flush_valid(flush_valid), .flush_all(flush_all), .flush_tag(flush_tag),
    .rb_valid(rb_valid), .rb_logical(rb_logical), .rb_prev_phys(rb_prev_phys),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int exp_q[$];
  int rb_q[$];
  logic [LW-1:0] m_log  [DEPTH];
  logic [PW-1:0] m_np   [DEPTH];
  logic [PW-1:0] m_pp   [DEPTH];
  logic          m_we   [DEPTH];
  logic          m_st   [DEPTH];
  logic          m_done [DEPTH];
  logic [DW-1:0] m_data [DEPTH];
  logic [DW-1:0] m_addr [DEPTH];
  logic [TW-1:0] mtail;
  logic [CW-1:0] last_cv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Compare DUT outputs against the scoreboard, then update it with this cycle's stimulus.
  task automatic sample();
    int n0, nrb, t;
    logic busy0, run, found;
    logic [CW-1:0] exp_cv;
    n0 = exp_q.size(); nrb = rb_q.size(); busy0 = (nrb > 0);
    chk("count", count, n0 + nrb);
    chk("busy", busy, busy0);
    chk("alloc_ready", alloc_ready, !busy0 && (n0 < DEPTH));
    chk("alloc_tag", alloc_tag, mtail);
    exp_cv = '0; run = !flush_valid && !busy0;
    for (int i = 0; i < CW; i++) begin
      if (i < n0) begin
        t = exp_q[i];
        run = run && m_done[t] && (!m_st[t] || (i == 0 && mem_ready));
      end else run = 1'b0;
      exp_cv[i] = run;
    end
    chk("commit_valid", commit_valid, exp_cv);
    last_cv = commit_valid;
    for (int i = 0; i < CW; i++) begin
      if (exp_cv[i]) begin
        t = exp_q.pop_front();
        if (commit_valid[i]) begin
          chk("c_phys",    commit_phys[i],      m_np[t]);
          chk("c_logical", commit_logical[i],   m_log[t]);
          chk("c_free",    commit_free_phys[i], m_pp[t]);
          chk("c_data",    commit_data[i],      m_data[t]);
          chk("c_addr",    commit_mem_addr[i],  m_addr[t]);
          chk("c_reg_we",  commit_reg_we[i],    m_we[t]);
          chk("c_mem_we",  commit_mem_we[i],    m_st[t]);
        end
      end
    end
    chk("rb_valid", rb_valid, busy0);
    if (busy0) begin
      t = rb_q.pop_front();
      chk("rb_logical", rb_logical, m_log[t]);
      chk("rb_prev",    rb_prev_phys, m_pp[t]);
      mtail = mtail - 1'b1;
    end
    if (wb_valid && !busy0) begin
      m_done[wb_tag] = 1'b1; m_data[wb_tag] = wb_data; m_addr[wb_tag] = wb_mem_addr;
    end
    if (alloc_valid && !flush_valid && !busy0 && n0 < DEPTH) begin
      t = int'(mtail);
      m_log[t] = alloc_logical; m_np[t] = alloc_new_phys; m_pp[t] = alloc_prev_phys;
      m_we[t] = alloc_reg_we; m_st[t] = alloc_is_store; m_done[t] = 1'b0;
      exp_q.push_back(t);
      mtail = mtail + 1'b1;
    end
    if (flush_valid && !busy0) begin
      if (flush_all) begin
        while (exp_q.size() > 0) rb_q.push_back(exp_q.pop_back());
      end else begin
        found = 1'b0;
        foreach (exp_q[k]) if (exp_q[k] == int'(flush_tag)) found = 1'b1;
        assert (found) else $error("flush_tag %0d not occupied", flush_tag);
        while (exp_q.size() > 0 && exp_q[$] != int'(flush_tag)) rb_q.push_back(exp_q.pop_back());
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (rst_n) sample();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    alloc_valid = 0; wb_valid = 0; flush_valid = 0; flush_all = 0;
  endtask

  task automatic drive_alloc(input int s, input logic st);
    logic [31:0] v;
    alloc_valid = 1; v = s; alloc_logical = v[LW-1:0];
    v = s * 5 + 3; alloc_new_phys = v[PW-1:0];
    v = s * 3 + 1; alloc_prev_phys = v[PW-1:0];
    alloc_reg_we = !st; alloc_is_store = st;
  endtask

  task automatic drive_wb(input int tag);
    logic [31:0] v;
    v = tag; wb_valid = 1; wb_tag = v[TW-1:0];
    wb_data = $urandom; wb_mem_addr = $urandom;
  endtask

  task automatic clear_model();
    exp_q.delete(); rb_q.delete(); mtail = '0;
    for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rb", rb_valid, 0);
    chk("rst_cv", commit_valid, 0);
  endtask

  task automatic do_reset();
    clr(); rst_n = 0; #1;
    reset_checks();
    clear_model();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) cyc();
  endtask

  initial begin
    #2;
    do_reset();

    // Out-of-order write-back, in-order retirement.
    for (int i = 0; i < 3; i++) begin drive_alloc(i + 1, 0); cyc(); end
    clr(); chk("t1_cnt3", count, 3);
    drive_wb(2); cyc(); clr(); chk("t1_after_wb2", count, 3);
    drive_wb(0); cyc(); clr(); chk("t1_no_same_cycle", last_cv, 2'b00);
    drive_wb(1); cyc(); clr();
    chk("t1_tag0_ret", last_cv, 2'b01); chk("t1_cnt2", count, 2);
    cyc();
    chk("t1_tag12_ret", last_cv, 2'b11); chk("t1_cnt0", count, 0);

    // Full buffer, refusal while committing, tail wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin drive_alloc(i + 10, 0); cyc(); end
    clr(); chk("t2_full_cnt", count, 32); chk("t2_full_ready", alloc_ready, 0);
    drive_wb(1); cyc(); drive_wb(0); cyc(); clr();
    drive_alloc(99, 0); cyc(); clr();
    chk("t2_cv", last_cv, 2'b11); chk("t2_cnt30", count, 30);
    chk("t2_ready", alloc_ready, 1); chk("t2_tag_wrap", alloc_tag, 0);
    for (int t = 2; t < DEPTH; t++) begin drive_wb(t); cyc(); end
    clr(); drain(); chk("t2_drained", count, 0);

    // Stores wait for mem_ready and only retire from slot 0.
    do_reset();
    mem_ready = 0;
    drive_alloc(50, 1); cyc(); drive_alloc(51, 1); cyc(); clr();
    drive_wb(0); cyc(); drive_wb(1); cyc(); clr();
    for (int k = 0; k < 3; k++) begin cyc(); chk("t3_hold", last_cv, 2'b00); end
    chk("t3_cnt2", count, 2);
    mem_ready = 1;
    cyc(); chk("t3_st0", last_cv, 2'b01); chk("t3_cnt1", count, 1);
    cyc(); chk("t3_st1", last_cv, 2'b01); chk("t3_cnt0", count, 0);
    drive_alloc(52, 0); cyc(); drive_alloc(53, 1); cyc(); clr();
    drive_wb(2); cyc(); drive_wb(3); cyc(); clr();
    drain(); chk("t3_mix_cnt", count, 0);

    // Partial flush: squash tags 5,4,3.
    do_reset();
    for (int i = 0; i < 6; i++) begin drive_alloc(i + 60, 0); cyc(); end
    clr(); flush_valid = 1; flush_tag = 5'd2; cyc(); clr();
    for (int k = 0; k < 3; k++) begin
      chk("t4_busy", busy, 1); chk("t4_rb", rb_valid, 1); cyc();
    end
    chk("t4_idle", busy, 0); chk("t4_tail", alloc_tag, 3);
    chk("t4_cnt", count, 3); chk("t4_ready", alloc_ready, 1);

    // flush_all through the wrap with head at 30.
    do_reset();
    for (int i = 0; i < 30; i++) begin drive_alloc(i, 0); cyc(); end
    clr();
    for (int t = 0; t < 30; t++) begin drive_wb(t); cyc(); end
    clr(); drain();
    chk("t5_cnt0", count, 0); chk("t5_tail30", alloc_tag, 30);
    for (int i = 0; i < 4; i++) begin drive_alloc(70 + i, 0); cyc(); end
    clr(); flush_valid = 1; flush_all = 1; flush_tag = '0; cyc(); clr();
    for (int k = 0; k < 4; k++) begin chk("t5_busy", busy, 1); cyc(); end
    chk("t5_after_cnt", count, 0); chk("t5_after_tail", alloc_tag, 30);
    chk("t5_after_busy", busy, 0);

    // Asynchronous reset in the second rollback cycle.
    for (int i = 0; i < 4; i++) begin drive_alloc(80 + i, 0); cyc(); end
    clr(); flush_valid = 1; flush_tag = 5'd30; cyc(); clr();
    chk("t6_rb1", rb_valid, 1);
    cyc();
    chk("t6_rb2", rb_valid, 1);
    rst_n = 0; #1;
    reset_checks();
    clear_model();
    @(negedge clk);
    chk("t6_rb_held", rb_valid, 0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
